// File: rtl/alucontrol_pkg.sv
// Shared opcode/funct/ALU-op constants for the exec-stage ALU control.
// FN_DIV/ALUOP_DIV only decode when ALUCTL_DIV_EN is defined.
package alucontrol_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_LDB      = 6'h01;
  localparam logic [5:0] OP_LDW      = 6'h02;
  localparam logic [5:0] OP_STB      = 6'h03;
  localparam logic [5:0] OP_STW      = 6'h04;
  localparam logic [5:0] OP_LI       = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h06;
  localparam logic [5:0] OP_BEQ      = 6'h07;
  localparam logic [5:0] OP_ORI      = 6'h08;
  localparam logic [5:0] OP_LUI      = 6'h09;
  localparam logic [5:0] OP_MOV      = 6'h0A;
  localparam logic [5:0] OP_JUMP     = 6'h0B;
  localparam logic [5:0] OP_TLBWRITE = 6'h0C;
  localparam logic [5:0] OP_IRET     = 6'h0D;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_DIV = 6'h1A;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  // Zero is reserved as the reset value of the registered op.
  localparam int ALUOP_ADD  = 1;
  localparam int ALUOP_SUB  = 2;
  localparam int ALUOP_ORI  = 3;
  localparam int ALUOP_LUI  = 4;
  localparam int ALUOP_MOV  = 5;
  localparam int ALUOP_JUMP = 6;
  localparam int ALUOP_SLL  = 7;
  localparam int ALUOP_MUL  = 8;
  localparam int ALUOP_DIV  = 9;

  localparam logic LAT_SEL_MUL = 1'b0;
  localparam logic LAT_SEL_DIV = 1'b1;

endpackage

// File: rtl/alucontrol_seq_decode.sv
// Combinational opcode/funct decode: ALU op, multi-cycle class, latency select,
// hold (no op change) and illegal flags. DIV decode gated by ALUCTL_DIV_EN.
module alucontrol_decode
  import alucontrol_pkg::*;
#(
  parameter int ALUOP_W = 5
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic [ALUOP_W-1:0] op,
  output logic               is_multi,
  output logic               lat_sel,
  output logic               hold,
  output logic               illegal
);

  always_comb begin
    op       = '0;
    is_multi = 1'b0;
    lat_sel  = LAT_SEL_MUL;
    hold     = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_LDB, OP_LDW, OP_STB, OP_STW, OP_LI, OP_ADDI: op = ALUOP_W'(ALUOP_ADD);
      OP_BEQ:                 op = ALUOP_W'(ALUOP_SUB);
      OP_ORI:                 op = ALUOP_W'(ALUOP_ORI);
      OP_LUI:                 op = ALUOP_W'(ALUOP_LUI);
      OP_MOV:                 op = ALUOP_W'(ALUOP_MOV);
      OP_JUMP:                op = ALUOP_W'(ALUOP_JUMP);
      OP_TLBWRITE, OP_IRET:   hold = 1'b1;
      OP_RTYPE: begin
        case (funct)
          FN_ADD: op = ALUOP_W'(ALUOP_ADD);
          FN_SUB: op = ALUOP_W'(ALUOP_SUB);
          FN_SLL: op = ALUOP_W'(ALUOP_SLL);
          FN_MUL: begin
            op       = ALUOP_W'(ALUOP_MUL);
            is_multi = 1'b1;
          end
`ifdef ALUCTL_DIV_EN
          FN_DIV: begin
            op       = ALUOP_W'(ALUOP_DIV);
            is_multi = 1'b1;
            lat_sel  = LAT_SEL_DIV;
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alucontrol_seq.sv
// Registered ALU control with valid/ready handshake and multi-cycle MUL/DIV
// scheduling. Optional DIV support: define ALUCTL_DIV_EN.
module alucontrol_seq
  import alucontrol_pkg::*;
#(
  parameter int ALUOP_W = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               flush,
  input  logic               out_ready,
  output logic               in_ready,
  output logic [ALUOP_W-1:0] aluop_out,
  output logic               out_valid,
  output logic               busy,
  output logic               illegal
);

`ifdef ALUCTL_DIV_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
`else
  localparam int MAX_LAT = MUL_LAT;
`endif
  localparam int CNT_W = $clog2(MAX_LAT + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_MULTI = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic               out_valid_q, out_valid_d;
  logic               illegal_q, illegal_d;

  logic [ALUOP_W-1:0] dec_op;
  logic               dec_multi, dec_lat_sel, dec_hold, dec_illegal;
  logic               accept, go_multi, multi_done;
  logic [CNT_W-1:0]   cnt_load;

  alucontrol_decode #(.ALUOP_W(ALUOP_W)) u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .op       (dec_op),
    .is_multi (dec_multi),
    .lat_sel  (dec_lat_sel),
    .hold     (dec_hold),
    .illegal  (dec_illegal)
  );

  // A latency of 1 makes MUL/DIV behave as ordinary single-cycle ops.
  assign go_multi   = dec_multi && ((dec_lat_sel == LAT_SEL_DIV) ? (DIV_LAT > 1) : (MUL_LAT > 1));
  assign cnt_load   = (dec_lat_sel == LAT_SEL_DIV) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
  assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept     = in_valid && in_ready;
  assign multi_done = (state_q == ST_MULTI) && (cnt_q <= CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      aluop_q     <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aluop_q     <= aluop_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && go_multi) begin
            state_d = ST_MULTI;
            cnt_d   = cnt_load;
          end
        end
        ST_MULTI: begin
          if (multi_done) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    aluop_d     = aluop_q;
    out_valid_d = out_valid_q;
    illegal_d   = 1'b0;
    if (flush) begin
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (multi_done) out_valid_d = 1'b1;
      if (accept) begin
        if (go_multi) begin
          aluop_d     = dec_op;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
          illegal_d   = dec_illegal;
          if (!dec_hold && !dec_illegal) aluop_d = dec_op;
        end
      end
    end
  end

  assign aluop_out = aluop_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_MULTI);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alucontrol_seq.sv
// Self-checking bench for alucontrol_seq: directed table, multi-cycle corner
// sequences, and a randomized run against a cycle-indexed reference model.
module tb_alucontrol_seq;
  import alucontrol_pkg::*;

  localparam int ALUOP_W = 5;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  logic clk, reset, in_valid, flush, out_ready;
  logic [5:0] opcode, funct;
  logic in_ready, out_valid, busy, illegal;
  logic [ALUOP_W-1:0] aluop_out;

  int errors = 0;
  int checks = 0;

  alucontrol_seq #(.ALUOP_W(ALUOP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode), .funct(funct),
    .flush(flush), .out_ready(out_ready), .in_ready(in_ready), .aluop_out(aluop_out),
    .out_valid(out_valid), .busy(busy), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit        iv;
    logic [5:0] opc;
    logic [5:0] fn;
    bit        ordy;
    bit        fl;
    bit        rdy;
    int        op;
    bit        v;
    bit        b;
    bit        il;
  } vec_t;

  vec_t tbl[$];

  // Reference model: expectations tracked by edge index, not by counter state.
  bit m_valid, m_busy, m_illegal, m_rdy;
  int m_op, m_done, edge_n;

  function automatic void ref_decode(input logic [5:0] opc, input logic [5:0] fn,
                                     output int kind, output int op, output int lat);
    kind = 0; op = 0; lat = 1;
    case (opc)
      OP_LDB, OP_LDW, OP_STB, OP_STW, OP_LI, OP_ADDI: op = ALUOP_ADD;
      OP_BEQ:  op = ALUOP_SUB;
      OP_ORI:  op = ALUOP_ORI;
      OP_LUI:  op = ALUOP_LUI;
      OP_MOV:  op = ALUOP_MOV;
      OP_JUMP: op = ALUOP_JUMP;
      OP_TLBWRITE, OP_IRET: kind = 1;
      OP_RTYPE: begin
        if (fn == FN_ADD) op = ALUOP_ADD;
        else if (fn == FN_SUB) op = ALUOP_SUB;
        else if (fn == FN_SLL) op = ALUOP_SLL;
        else if (fn == FN_MUL) begin op = ALUOP_MUL; lat = MUL_LAT; end
`ifdef ALUCTL_DIV_EN
        else if (fn == FN_DIV) begin op = ALUOP_DIV; lat = DIV_LAT; end
`endif
        else kind = 2;
      end
      default: kind = 2;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_busy = 0; m_illegal = 0; m_op = 0; m_done = -1; edge_n = 0;
  endtask

  task automatic model_edge();
    int kind, op, lat;
    bit acc;
    edge_n++;
    acc = in_valid && m_rdy;
    if (flush) begin
      m_valid = 0; m_busy = 0; m_illegal = 0;
    end else begin
      m_illegal = 0;
      if (m_valid && out_ready) m_valid = 0;
      if (m_busy) begin
        if (edge_n == m_done) begin m_busy = 0; m_valid = 1; end
      end else if (acc) begin
        ref_decode(opcode, funct, kind, op, lat);
        if (lat > 1) begin
          m_op = op; m_busy = 1; m_done = edge_n + lat - 1; m_valid = 0;
        end else begin
          m_valid = 1;
          if (kind == 0) m_op = op;
          m_illegal = (kind == 2);
        end
      end
    end
  endtask

  logic [5:0] opc_pool[16];
  logic [5:0] fn_pool[7];

  initial begin
    int k, bound;
    reset = 1; in_valid = 0; opcode = 0; funct = 0; flush = 0; out_ready = 1;
    #12;
    chk("rst_aluop", aluop_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk); reset = 0;
    #1 chk("rst_in_ready", in_ready, 1);

    //             iv opc          fn     ordy fl rdy op          v b il
    tbl.push_back('{1, OP_ADDI,    6'h0,   1, 0, 1, ALUOP_ADD,  1, 0, 0});
    tbl.push_back('{1, OP_RTYPE,   FN_MUL, 1, 0, 1, ALUOP_MUL,  0, 1, 0});
    tbl.push_back('{1, OP_RTYPE,   FN_ADD, 1, 0, 0, ALUOP_MUL,  0, 1, 0});
    tbl.push_back('{1, OP_RTYPE,   FN_ADD, 1, 0, 0, ALUOP_MUL,  1, 0, 0});
    tbl.push_back('{1, OP_RTYPE,   FN_ADD, 1, 0, 1, ALUOP_ADD,  1, 0, 0});
    tbl.push_back('{1, OP_ORI,     6'h0,   1, 0, 1, ALUOP_ORI,  1, 0, 0});
    tbl.push_back('{1, OP_TLBWRITE,6'h0,   1, 0, 1, ALUOP_ORI,  1, 0, 0});
    tbl.push_back('{1, OP_RTYPE,   6'h3F,  1, 0, 1, ALUOP_ORI,  1, 0, 1});
    tbl.push_back('{0, OP_ADDI,    6'h0,   1, 0, 1, ALUOP_ORI,  0, 0, 0});
    tbl.push_back('{1, OP_LUI,     6'h0,   0, 0, 1, ALUOP_LUI,  1, 0, 0});
    tbl.push_back('{1, OP_MOV,     6'h0,   0, 0, 0, ALUOP_LUI,  1, 0, 0});
    tbl.push_back('{1, OP_MOV,     6'h0,   1, 0, 1, ALUOP_MOV,  1, 0, 0});
    tbl.push_back('{1, OP_RTYPE,   FN_MUL, 1, 0, 1, ALUOP_MUL,  0, 1, 0});
    tbl.push_back('{1, OP_ADDI,    6'h0,   1, 1, 0, ALUOP_MUL,  0, 0, 0});
    tbl.push_back('{1, OP_ADDI,    6'h0,   1, 0, 1, ALUOP_ADD,  1, 0, 0});
    tbl.push_back('{1, OP_BEQ,     6'h0,   1, 0, 1, ALUOP_SUB,  1, 0, 0});
    tbl.push_back('{1, OP_JUMP,    6'h0,   1, 0, 1, ALUOP_JUMP, 1, 0, 0});

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; opcode = tbl[i].opc; funct = tbl[i].fn;
      out_ready = tbl[i].ordy; flush = tbl[i].fl;
      #1 chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_aluop", i), aluop_out, tbl[i].op);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].v);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
      chk($sformatf("tbl%0d_illegal", i), illegal, tbl[i].il);
    end
    flush = 0;

    // DIV: accept, then count edges until out_valid.
    in_valid = 1; opcode = OP_RTYPE; funct = FN_DIV; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
`ifdef ALUCTL_DIV_EN
    k = 0; bound = 0;
    while (!out_valid && bound < 20) begin
      @(posedge clk); #1; k++; bound++;
    end
    chk("div_latency_edges", k, DIV_LAT - 1);
    chk("div_aluop", aluop_out, ALUOP_DIV);
`else
    chk("div_illegal", illegal, 1);
    chk("div_valid", out_valid, 1);
    chk("div_aluop_held", aluop_out, ALUOP_JUMP);
    @(posedge clk); #1;
    chk("div_illegal_pulse", illegal, 0);
`endif

    // Reset in the middle of a MUL.
    @(posedge clk); #1;
    in_valid = 1; opcode = OP_RTYPE; funct = FN_MUL; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    chk("mrst_busy_before", busy, 1);
    #2 reset = 1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_aluop", aluop_out, 0);
    chk("mrst_illegal", illegal, 0);
    @(negedge clk); reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_valid", out_valid, 0);
    end

    // Randomized run against the model.
    opc_pool = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_LDB, OP_LDW, OP_STB, OP_STW, OP_LI,
                 OP_ADDI, OP_BEQ, OP_ORI, OP_LUI, OP_MOV, OP_JUMP, OP_TLBWRITE, 6'h3E};
    fn_pool  = '{FN_ADD, FN_SUB, FN_SLL, FN_MUL, FN_MUL, FN_DIV, 6'h3F};
    reset = 1; #1 model_reset(); reset = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(15) == 0);
      opcode    = ($urandom_range(15) == 15) ? OP_IRET : opc_pool[$urandom_range(15)];
      funct     = fn_pool[$urandom_range(6)];
      m_rdy     = !m_busy && (!m_valid || out_ready) && !flush;
      #1 chk("rnd_in_ready", in_ready, m_rdy);
      @(posedge clk); #1;
      model_edge();
      chk("rnd_aluop", aluop_out, m_op);
      chk("rnd_valid", out_valid, m_valid);
      chk("rnd_busy", busy, m_busy);
      chk("rnd_illegal", illegal, m_illegal);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
